// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, key codes and column/key helper functions
// for the 4x4 keypad scanner.
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = KEY_0;
    case ({row_idx, col_idx})
      4'd0:  code = KEY_1;
      4'd1:  code = KEY_2;
      4'd2:  code = KEY_3;
      4'd3:  code = KEY_A;
      4'd4:  code = KEY_4;
      4'd5:  code = KEY_5;
      4'd6:  code = KEY_6;
      4'd7:  code = KEY_B;
      4'd8:  code = KEY_7;
      4'd9:  code = KEY_8;
      4'd10: code = KEY_9;
      4'd11: code = KEY_C;
      4'd12: code = KEY_STAR;
      4'd13: code = KEY_0;
      4'd14: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Columns are active-low; the lowest-numbered low column wins.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
    logic [1:0] idx;
    if (!cols[0])      idx = 2'd0;
    else if (!cols[1]) idx = 2'd1;
    else if (!cols[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser; resets to all-ones so an idle active-low
// keypad reads as "no key" from the first cycle.
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// keypad_scanner: rotates an active-low row strobe over a 4x4 keypad, debounces
// presses and releases, and emits one key_pressed pulse per accepted press.
`default_nettype none

module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_pressed,
  output logic [3:0] keypad_out,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]       col_s;
  logic [DIV_W-1:0] dwell;
  logic [1:0]       row_idx;
  logic [1:0]       cap_col;
  logic [CNT_W-1:0] count;
  state_t           state;

  logic             dwell_end;
  logic             hit;
  logic [1:0]       col_idx;
  logic             match;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] press_count;

  sync_2ff #(.WIDTH(4)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_in),
    .q   (col_s)
  );

  assign dwell_end   = (dwell == DWELL_LAST);
  assign hit         = (col_s != 4'hF);
  assign col_idx     = lowest_low_col(col_s);
  assign count_inc   = count + CNT_W'(1);
  // A fresh capture from SCAN always counts as the first matching sample.
  assign match       = hit && ((state == SCAN) || (col_idx == cap_col));
  assign press_count = (state == SCAN) ? CNT_W'(1) : count_inc;
  assign row_out     = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell       <= '0;
      row_idx     <= 2'd0;
      cap_col     <= 2'd0;
      count       <= '0;
      state       <= SCAN;
      key_pressed <= 1'b0;
      keypad_out  <= 4'h0;
      key_held    <= 1'b0;
    end else begin
      key_pressed <= 1'b0;
      dwell       <= dwell_end ? '0 : dwell + DIV_W'(1);
      if (dwell_end) begin
        case (state)
          SCAN, DEBOUNCE: begin
            if (!match) begin
              state   <= SCAN;
              count   <= '0;
              row_idx <= row_idx + 2'd1;
            end else if (press_count == CNT_TARGET) begin
              state       <= HELD;
              count       <= '0;
              key_pressed <= 1'b1;
              keypad_out  <= key_code(row_idx, col_idx);
              key_held    <= 1'b1;
            end else begin
              state   <= DEBOUNCE;
              count   <= press_count;
              cap_col <= col_idx;
            end
          end
          HELD: begin
            // Any low column, even a different key, keeps the release pending.
            if (hit) begin
              count <= '0;
            end else if (count_inc == CNT_TARGET) begin
              state    <= SCAN;
              count    <= '0;
              key_held <= 1'b0;
              row_idx  <= row_idx + 2'd1;
            end else begin
              count <= count_inc;
            end
          end
          default: begin
            state <= SCAN;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios against a sample-level model of
// the scanner, plus literal expectations on pulse codes and row sequencing.
`default_nettype none

module tb_keypad_scanner;

  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam logic [3:0] CODE [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'hE, 4'h0, 4'hF, 4'hD};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       key_pressed;
  logic [3:0] keypad_out;
  logic       key_held;
  logic [15:0] pressed;   // physical key matrix, index row*4+col

  int errors = 0;
  int checks = 0;
  logic [3:0] pulses[$];
  logic       prev_kp;

  keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .col_in      (col_in),
    .row_out     (row_out),
    .key_pressed (key_pressed),
    .keypad_out  (keypad_out),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; unpressed columns float high.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: col samples delayed two clocks, one decision per dwell end.
  int         m_dwell, m_row, m_mode, m_cnt, m_col;
  logic [3:0] m_s1, m_s2, m_out;
  logic       m_kp, m_held;

  task automatic model_sample(input logic [3:0] cols);
    int low;
    low = -1;
    for (int c = 3; c >= 0; c--) if (!cols[c]) low = c;
    if (m_mode == 2) begin
      if (low >= 0) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt == DEB) begin
          m_held = 1'b0; m_cnt = 0; m_row = (m_row + 1) % 4; m_mode = 0;
        end
      end
    end else if (low < 0 || (m_mode == 1 && low != m_col)) begin
      m_mode = 0; m_cnt = 0; m_row = (m_row + 1) % 4;
    end else begin
      m_cnt = (m_mode == 0) ? 1 : m_cnt + 1;
      m_col = low;
      if (m_cnt == DEB) begin
        m_kp = 1'b1; m_out = CODE[m_row*4 + low]; m_held = 1'b1; m_mode = 2; m_cnt = 0;
      end else m_mode = 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    logic [3:0] seen;
    if (rst) begin
      m_dwell = 0; m_row = 0; m_mode = 0; m_cnt = 0; m_col = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_out = 4'h0; m_kp = 1'b0; m_held = 1'b0;
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = col_in;
      m_kp = 1'b0;
      if (m_dwell == DIV - 1) model_sample(seen);
      m_dwell = (m_dwell + 1) % DIV;
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_row;
    logic [3:0] one;
    if (!rst) begin
      one     = 4'b0001;
      exp_row = ~(one << m_row);
      chk("row_out", row_out, exp_row);
      chk("key_pressed", key_pressed, m_kp);
      chk("keypad_out", keypad_out, m_out);
      chk("key_held", key_held, m_held);
      chk("pulse_gap", prev_kp & key_pressed, 1'b0);
      if (key_pressed) pulses.push_back(keypad_out);
      prev_kp = key_pressed;
    end else prev_kp = 1'b0;
  end

  task automatic wait_row(input logic [3:0] r);
    int n;
    n = 0;
    while (row_out !== r && n < 64) begin @(negedge clk); n++; end
    if (row_out !== r) chk("wait_row_timeout", row_out, r);
  endtask

  task automatic wait_held_low(input int budget);
    int n;
    n = 0;
    while (key_held !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    if (key_held !== 1'b0) chk("held_release_timeout", key_held, 1'b0);
  endtask

  task automatic check_pulses(input string name, input int n, input logic [3:0] c0, input logic [3:0] c1);
    chk({name, "_count"}, pulses.size(), n);
    if (n > 0) chk({name, "_code0"}, (pulses.size() > 0) ? pulses[0] : 4'hx, c0);
    if (n > 1) chk({name, "_code1"}, (pulses.size() > 1) ? pulses[1] : 4'hx, c1);
  endtask

  logic [3:0] idle_exp [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    pressed = 16'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_row_out", row_out, 4'b1110);
    chk("rst_key_pressed", key_pressed, 1'b0);
    chk("rst_keypad_out", keypad_out, 4'h0);
    chk("rst_key_held", key_held, 1'b0);

    // Idle rotation
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n <= 17 && n % 4 == 1) chk("idle_row", row_out, idle_exp[n/4]);
    end
    check_pulses("idle", 0, 4'h0, 4'h0);

    // Key 5 held then released
    pulses.delete();
    pressed[5] = 1'b1;
    repeat (100) @(negedge clk);
    chk("k5_held", key_held, 1'b1);
    pressed = 16'h0;
    wait_held_low(100);
    chk("k5_resume_row2", row_out, 4'b1011);
    check_pulses("k5", 1, 4'h5, 4'h0);
    repeat (20) @(negedge clk);

    // Bouncing '#'
    pulses.delete();
    wait_row(4'b0111);
    for (int i = 0; i < 4; i++) begin
      pressed[14] = ~pressed[14];
      repeat (4) @(negedge clk);
    end
    chk("hash_bounce_no_pulse", pulses.size(), 0);
    pressed[14] = 1'b1;
    repeat (80) @(negedge clk);
    check_pulses("hash", 1, 4'hF, 4'h0);
    pressed = 16'h0;
    wait_held_low(100);
    repeat (10) @(negedge clk);

    // Two columns on row 0
    pulses.delete();
    pressed[1] = 1'b1;
    pressed[3] = 1'b1;
    repeat (60) @(negedge clk);
    check_pulses("multi", 1, 4'h2, 4'h0);
    pressed = 16'h0;
    wait_held_low(100);
    repeat (10) @(negedge clk);

    // '7' held, '9' joins, '7' released with '9' still down
    pulses.delete();
    pressed[8] = 1'b1;
    repeat (60) @(negedge clk);
    check_pulses("seven", 1, 4'h7, 4'h0);
    pressed[10] = 1'b1;
    repeat (20) @(negedge clk);
    pressed[8] = 1'b0;
    repeat (60) @(negedge clk);
    chk("nine_blocks_release", key_held, 1'b1);
    chk("nine_not_reported", pulses.size(), 1);
    pressed[10] = 1'b0;
    wait_held_low(100);
    repeat (10) @(negedge clk);
    pressed[10] = 1'b1;
    repeat (60) @(negedge clk);
    check_pulses("seven_nine", 2, 4'h7, 4'h9);
    pressed = 16'h0;
    wait_held_low(100);
    repeat (10) @(negedge clk);

    // Reset mid-debounce on '0'
    pulses.delete();
    wait_row(4'b1110);
    pressed[13] = 1'b1;
    wait_row(4'b0111);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_row_out", row_out, 4'b1110);
    chk("mid_rst_key_held", key_held, 1'b0);
    chk("mid_rst_key_pressed", key_pressed, 1'b0);
    chk("mid_rst_no_pulse", pulses.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check_pulses("zero_after_rst", 1, 4'h0, 4'h0);
    pressed = 16'h0;
    wait_held_low(100);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
